sccb_config_sequencer: RTL and testbench

- Parametrised sensor-configuration sequencer; next generation of the camera register-load path.
- Walks a register table in a synchronous ROM and drives a byte-level SCCB master through a start/ready handshake.
- Adds over the current loader: configurable widths and depth, device ID, embedded delay and end entries, optional read-back verify with bounded retry, NACK handling, and error/progress status.
- Sits between the config ROM and the SCCB master, under the camera top level.

---
 rtl/sccb_config_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_sccb_config_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : sccb_config_sequencer
// Purpose : Walks a {reg, value} table in a synchronous ROM and issues SCCB
//           register writes through a byte-level master, with embedded delay
//           and end entries, optional read-back verify with bounded retry,
//           NACK handling and error/progress status.
// Rev     : 1.0  initial release
// ============================================================================
module sccb_config_sequencer #(
  parameter int unsigned CLK_FREQ  = 25000000,
  parameter int unsigned ROM_AW    = 8,
  parameter int unsigned REG_AW    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter logic [7:0]  DEV_ID    = 8'h42,
  parameter bit          VERIFY    = 1'b0,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [ROM_AW-1:0]        rom_addr,
  input  logic [REG_AW+DATA_W-1:0] rom_dout,
  output logic                     m_start,
  output logic                     m_rw,
  output logic [7:0]               m_dev_id,
  output logic [REG_AW-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic                     m_ready,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic                     m_nack,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [7:0]               fail_count
);

  localparam int unsigned CYC_PER_MS = CLK_FREQ / 1000;
  localparam int unsigned DLY_MAX    = 255 * CYC_PER_MS;
  localparam int unsigned DLY_W      = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX + 1);
  localparam logic [DLY_W-1:0] CPM_V = DLY_W'(CYC_PER_MS);
  localparam logic [3:0]   MAX_R     = 4'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_WR_REQ  = 4'd3,
    S_WR_WAIT = 4'd4,
    S_RD_REQ  = 4'd5,
    S_RD_WAIT = 4'd6,
    S_CHECK   = 4'd7,
    S_DELAY   = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  state_t              state, state_n;
  logic [ROM_AW-1:0]   rom_addr_n;
  logic                m_start_n, m_rw_n;
  logic [REG_AW-1:0]   m_addr_n;
  logic [DATA_W-1:0]   m_wdata_n;
  logic                busy_n, done_n, error_n;
  logic [7:0]          fail_count_n;
  logic [DLY_W-1:0]    dly_cnt, dly_cnt_n;
  logic [3:0]          retry_cnt, retry_cnt_n;
  logic                advance, fail;

  logic [REG_AW-1:0]   ent_reg;
  logic [DATA_W-1:0]   ent_val;

  assign ent_reg  = rom_dout[REG_AW+DATA_W-1 -: REG_AW];
  assign ent_val  = rom_dout[DATA_W-1:0];
  assign m_dev_id = DEV_ID;

  // State and all registered outputs; reset abandons any transaction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rom_addr   <= '0;
      m_start    <= 1'b0;
      m_rw       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      fail_count <= '0;
      dly_cnt    <= '0;
      retry_cnt  <= '0;
    end else begin
      state      <= state_n;
      rom_addr   <= rom_addr_n;
      m_start    <= m_start_n;
      m_rw       <= m_rw_n;
      m_addr     <= m_addr_n;
      m_wdata    <= m_wdata_n;
      busy       <= busy_n;
      done       <= done_n;
      error      <= error_n;
      fail_count <= fail_count_n;
      dly_cnt    <= dly_cnt_n;
      retry_cnt  <= retry_cnt_n;
    end
  end

  // Next-state logic: table walk, handshake, verify, retry and advance.
  always_comb begin
    state_n      = state;
    rom_addr_n   = rom_addr;
    m_start_n    = 1'b0;
    m_rw_n       = m_rw;
    m_addr_n     = m_addr;
    m_wdata_n    = m_wdata;
    busy_n       = busy;
    done_n       = done;
    error_n      = error;
    fail_count_n = fail_count;
    dly_cnt_n    = dly_cnt;
    retry_cnt_n  = retry_cnt;
    advance      = 1'b0;
    fail         = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_n       = 1'b0;
          error_n      = 1'b0;
          fail_count_n = '0;
          retry_cnt_n  = '0;
          rom_addr_n   = '0;
          busy_n       = 1'b1;
          state_n      = S_FETCH;
        end
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        if (&ent_reg) begin
          if (&ent_val) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            // A zero-length delay still spends one cycle in DELAY.
            dly_cnt_n = (ent_val == '0) ? '0
                                        : DLY_W'(ent_val) * CPM_V - DLY_W'(1);
            state_n   = S_DELAY;
          end
        end else begin
          m_addr_n  = ent_reg;
          m_wdata_n = ent_val;
          state_n   = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (m_ready) begin
          m_start_n = 1'b1;
          m_rw_n    = 1'b0;
          state_n   = S_WR_WAIT;
        end
      end
      S_RD_REQ: begin
        if (m_ready) begin
          m_start_n = 1'b1;
          m_rw_n    = 1'b1;
          state_n   = S_RD_WAIT;
        end
      end
      // While m_start is still high the master has not yet dropped ready.
      S_WR_WAIT: begin
        if (!m_start && m_ready) begin
          if (m_nack)      fail    = 1'b1;
          else if (VERIFY) state_n = S_RD_REQ;
          else             advance = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (!m_start && m_ready) begin
          if (m_nack) fail    = 1'b1;
          else        state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (m_rdata == m_wdata) advance = 1'b1;
        else                    fail    = 1'b1;
      end
      S_DELAY: begin
        if (dly_cnt == '0) advance   = 1'b1;
        else               dly_cnt_n = dly_cnt - DLY_W'(1);
      end
      default: state_n = S_IDLE;
    endcase

    if (fail) begin
      if (retry_cnt < MAX_R) begin
        retry_cnt_n = retry_cnt + 4'd1;
        state_n     = S_WR_REQ;
      end else begin
        error_n = 1'b1;
        if (fail_count != 8'hFF) fail_count_n = fail_count + 8'd1;
        advance = 1'b1;
      end
    end

    // Table overrun (no end marker) finishes the sequence with an error.
    if (advance) begin
      retry_cnt_n = '0;
      if (&rom_addr) begin
        error_n = 1'b1;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = S_DONE;
      end else begin
        rom_addr_n = rom_addr + ROM_AW'(1);
        state_n    = S_FETCH;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sccb_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sccb_config_sequencer
// Purpose : Self-checking bench for sccb_config_sequencer. Instance 0 runs
//           without verify, instance 1 with verify; both use CLK_FREQ=1000
//           (1 cycle per ms) and a 4-entry table. A scoreboard holds the
//           expected master transactions in issue order.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sccb_config_sequencer;

  typedef struct packed {
    logic       inst;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start [2];
  logic        m_start [2], m_rw [2], m_ready [2], m_nack [2];
  logic        busy [2], done [2], error [2];
  logic [1:0]  rom_addr [2];
  logic [15:0] rom_dout [2];
  logic [7:0]  m_dev_id [2], m_addr [2], m_wdata [2], m_rdata [2], fail_count [2];
  logic [15:0] rom [2][4];

  int          lat;
  logic        nack_mode;
  logic [7:0]  rdq [$];
  txn_t        exp_q [$];
  int          lat_cnt [2];
  logic        rd_pend [2];
  int          pulses [2];
  int          n_checks = 0;
  int          n_fail   = 0;
  txn_t        e;

  sccb_config_sequencer #(
    .CLK_FREQ(1000), .ROM_AW(2), .REG_AW(8), .DATA_W(8),
    .DEV_ID(8'h42), .VERIFY(1'b0), .MAX_RETRY(3)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .rom_addr(rom_addr[0]), .rom_dout(rom_dout[0]),
    .m_start(m_start[0]), .m_rw(m_rw[0]), .m_dev_id(m_dev_id[0]),
    .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_ready(m_ready[0]),
    .m_rdata(m_rdata[0]), .m_nack(m_nack[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0]), .fail_count(fail_count[0])
  );

  sccb_config_sequencer #(
    .CLK_FREQ(1000), .ROM_AW(2), .REG_AW(8), .DATA_W(8),
    .DEV_ID(8'h42), .VERIFY(1'b1), .MAX_RETRY(3)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .rom_addr(rom_addr[1]), .rom_dout(rom_dout[1]),
    .m_start(m_start[1]), .m_rw(m_rw[1]), .m_dev_id(m_dev_id[1]),
    .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_ready(m_ready[1]),
    .m_rdata(m_rdata[1]), .m_nack(m_nack[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1]), .fail_count(fail_count[1])
  );

  // Synchronous ROMs with one cycle of read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) rom_dout[i] <= rom[i][rom_addr[i]];
  end

  // SCCB master model: ready returns lat cycles after m_start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_ready[i] <= 1'b1; m_nack[i] <= 1'b0; m_rdata[i] <= 8'h00;
        lat_cnt[i] <= 0;    rd_pend[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_start[i]) begin
          m_ready[i] <= 1'b0;
          lat_cnt[i] <= lat;
          rd_pend[i] <= m_rw[i];
        end else if (lat_cnt[i] != 0) begin
          lat_cnt[i] <= lat_cnt[i] - 1;
          if (lat_cnt[i] == 1) begin
            m_ready[i] <= 1'b1;
            m_nack[i]  <= nack_mode;
            if (rd_pend[i]) begin
              if (rdq.size() > 0) m_rdata[i] <= rdq.pop_front();
              else                m_rdata[i] <= 8'h34;
            end
          end
        end
      end
    end
  end

  // Scoreboard: every m_start pulse must match the next expected transaction.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_start[i] === 1'b1) begin
        pulses[i]++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL txn_unexpected dut%0d: got rw=%0b addr=%h data=%h, required none",
                   i, m_rw[i], m_addr[i], m_wdata[i]);
        end else begin
          e = exp_q.pop_front();
          if (e.inst !== 1'(i) || m_rw[i] !== e.rw || m_addr[i] !== e.addr ||
              m_wdata[i] !== e.wdata) begin
            n_fail++;
            $display("FAIL txn dut%0d: got rw=%0b addr=%h data=%h, required dut%0d rw=%0b addr=%h data=%h",
                     i, m_rw[i], m_addr[i], m_wdata[i], e.inst, e.rw, e.addr, e.wdata);
          end
        end
      end
    end
  end

  task automatic push_txn(input int i, input logic rw, input logic [7:0] a,
                          input logic [7:0] d, input int reps);
    for (int k = 0; k < reps; k++) exp_q.push_back({1'(i), rw, a, d});
  endtask

  task automatic load_rom(input int i, input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] a2, input logic [15:0] a3);
    rom[i][0] = a0; rom[i][1] = a1; rom[i][2] = a2; rom[i][3] = a3;
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk) start[i] = 1'b1;
    @(negedge clk) start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    for (int c = 0; c < 3000; c++) begin
      if (done[i] === 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({rom_addr[i], m_start[i], m_rw[i], m_addr[i], m_wdata[i]} !== 20'h0) begin
        n_fail++;
        $display("FAIL reset_bus dut%0d: got addr=%h start=%b rw=%b reg=%h data=%h, required all 0",
                 i, rom_addr[i], m_start[i], m_rw[i], m_addr[i], m_wdata[i]);
      end
      n_checks++;
      if ({busy[i], done[i], error[i], fail_count[i]} !== 11'h0) begin
        n_fail++;
        $display("FAIL reset_status dut%0d: got busy=%b done=%b err=%b fc=%0d, required 0",
                 i, busy[i], done[i], error[i], fail_count[i]);
      end
      n_checks++;
      if (m_dev_id[i] !== 8'h42) begin
        n_fail++;
        $display("FAIL dev_id dut%0d: got %h, required 42", i, m_dev_id[i]);
      end
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_write_seq();
    lat = 10; nack_mode = 1'b0; pulses[0] = 0;
    load_rom(0, 16'h1280, 16'h1100, 16'hFFFF, 16'h0000);
    push_txn(0, 1'b0, 8'h12, 8'h80, 1);
    push_txn(0, 1'b0, 8'h11, 8'h00, 1);
    pulse_start(0);
    wait_done(0);
    n_checks++;
    if ({done[0], busy[0], error[0]} !== 3'b100 || fail_count[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL write_status: got done=%b busy=%b err=%b fc=%0d, required 1 0 0 0",
               done[0], busy[0], error[0], fail_count[0]);
    end
    n_checks++;
    if (pulses[0] !== 2 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL write_pulses: got %0d pulses, %0d pending, required 2 and 0",
               pulses[0], exp_q.size());
    end
    n_checks++;
    if (rom_addr[0] !== 2'd2) begin
      n_fail++;
      $display("FAIL write_end_addr: got %0d, required 2", rom_addr[0]);
    end
  endtask

  task automatic test_delay(input logic [7:0] ms, input int exp_gap);
    int gap;
    lat = 10; nack_mode = 1'b0;
    load_rom(0, {8'hFF, ms}, 16'h1234, 16'hFFFF, 16'h0000);
    push_txn(0, 1'b0, 8'h12, 8'h34, 1);
    pulse_start(0);
    gap = 0;
    while (m_start[0] !== 1'b1 && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    wait_done(0);
    n_checks++;
    if (gap !== exp_gap) begin
      n_fail++;
      $display("FAIL delay_gap_%0dms: got %0d cycles, required %0d", ms, gap, exp_gap);
    end
    n_checks++;
    if (done[0] !== 1'b1 || error[0] !== 1'b0 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL delay_status_%0dms: got done=%b err=%b pending=%0d, required 1 0 0",
               ms, done[0], error[0], exp_q.size());
    end
  endtask

  task automatic test_verify(input int bad_reads, input logic exp_err);
    lat = 3; nack_mode = 1'b0; pulses[1] = 0;
    load_rom(1, 16'h1234, 16'hFFFF, 16'h0000, 16'h0000);
    rdq.delete();
    for (int k = 0; k < bad_reads; k++) rdq.push_back(8'h35);
    if (bad_reads < 4) rdq.push_back(8'h34);
    for (int k = 0; k < ((bad_reads < 4) ? bad_reads + 1 : 4); k++) begin
      push_txn(1, 1'b0, 8'h12, 8'h34, 1);
      push_txn(1, 1'b1, 8'h12, 8'h34, 1);
    end
    pulse_start(1);
    wait_done(1);
    n_checks++;
    if (done[1] !== 1'b1 || error[1] !== exp_err ||
        fail_count[1] !== (exp_err ? 8'd1 : 8'd0)) begin
      n_fail++;
      $display("FAIL verify_%0dbad_status: got done=%b err=%b fc=%0d, required 1 %b %0d",
               bad_reads, done[1], error[1], fail_count[1], exp_err, exp_err);
    end
    n_checks++;
    if (pulses[1] !== 2 * ((bad_reads < 4) ? bad_reads + 1 : 4) ||
        exp_q.size() !== 0 || rdq.size() !== 0) begin
      n_fail++;
      $display("FAIL verify_%0dbad_pulses: got %0d pulses, %0d pending, %0d reads left",
               bad_reads, pulses[1], exp_q.size(), rdq.size());
    end
  endtask

  task automatic test_nack();
    lat = 10; nack_mode = 1'b1; pulses[0] = 0;
    load_rom(0, 16'h1234, 16'h5678, 16'hFFFF, 16'h0000);
    push_txn(0, 1'b0, 8'h12, 8'h34, 4);
    push_txn(0, 1'b0, 8'h56, 8'h78, 4);
    pulse_start(0);
    wait_done(0);
    nack_mode = 1'b0;
    n_checks++;
    if (done[0] !== 1'b1 || error[0] !== 1'b1 || fail_count[0] !== 8'd2) begin
      n_fail++;
      $display("FAIL nack_status: got done=%b err=%b fc=%0d, required 1 1 2",
               done[0], error[0], fail_count[0]);
    end
    n_checks++;
    if (pulses[0] !== 8 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL nack_pulses: got %0d pulses, %0d pending, required 8 and 0",
               pulses[0], exp_q.size());
    end
  endtask

  task automatic test_overrun();
    int c;
    lat = 10; nack_mode = 1'b0; pulses[0] = 0;
    load_rom(0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    push_txn(0, 1'b0, 8'h11, 8'h11, 1);
    push_txn(0, 1'b0, 8'h22, 8'h22, 1);
    push_txn(0, 1'b0, 8'h33, 8'h33, 1);
    push_txn(0, 1'b0, 8'h44, 8'h44, 1);
    pulse_start(0);
    c = 0;
    while (m_start[0] !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    start[0] = 1'b1;
    repeat (5) @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);
    n_checks++;
    if (done[0] !== 1'b1 || error[0] !== 1'b1 || rom_addr[0] !== 2'd3) begin
      n_fail++;
      $display("FAIL overrun_status: got done=%b err=%b addr=%0d, required 1 1 3",
               done[0], error[0], rom_addr[0]);
    end
    n_checks++;
    if (pulses[0] !== 4 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL overrun_pulses: got %0d pulses, %0d pending, required 4 and 0",
               pulses[0], exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int c;
    lat = 10; nack_mode = 1'b0; pulses[0] = 0;
    load_rom(0, 16'h1234, 16'hFFFF, 16'h0000, 16'h0000);
    push_txn(0, 1'b0, 8'h12, 8'h34, 1);
    pulse_start(0);
    c = 0;
    while (m_start[0] !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b1 || m_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_precond: got busy=%b ready=%b, required 1 0", busy[0], m_ready[0]);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy[0], done[0], error[0], m_start[0], m_rw[0], rom_addr[0],
         m_addr[0], m_wdata[0], fail_count[0]} !== 33'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b done=%b err=%b start=%b addr=%0d reg=%h data=%h, required 0",
               busy[0], done[0], error[0], m_start[0], rom_addr[0], m_addr[0], m_wdata[0]);
    end
    @(negedge clk) rst = 1'b0;
    pulses[0] = 0;
    push_txn(0, 1'b0, 8'h12, 8'h34, 1);
    pulse_start(0);
    n_checks++;
    if (busy[0] !== 1'b1 || rom_addr[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_restart: got busy=%b addr=%0d, required 1 0", busy[0], rom_addr[0]);
    end
    wait_done(0);
    n_checks++;
    if (done[0] !== 1'b1 || error[0] !== 1'b0 || pulses[0] !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL mid_rerun: got done=%b err=%b pulses=%0d pending=%0d, required 1 0 1 0",
               done[0], error[0], pulses[0], exp_q.size());
    end
  endtask

  initial begin
    start[0] = 1'b0; start[1] = 1'b0;
    lat = 10; nack_mode = 1'b0;
    pulses[0] = 0; pulses[1] = 0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) rom[i][k] = 16'hFFFF;
    test_reset();
    test_write_seq();
    test_delay(8'd2, 7);
    test_delay(8'd0, 6);
    test_verify(0, 1'b0);
    test_verify(3, 1'b0);
    test_verify(4, 1'b1);
    test_nack();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
